// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Single-cycle mem_ack completes a request held on mem_req.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: checks legality, drives one req/ack bus transaction per
// load/store, lane-aligns store data and extends load data, stalling the core meanwhile.
module load_store_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmem_read_en,
    input  logic              dmem_write_en,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              fault,
    load_store_unit_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               req_any, req_write, legal;
    logic [3:0]         be_c;
    logic [DATA_W-1:0]  wdata_c;

    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         off_q;
    logic [2:0]         func3_q;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [3:0]         be_q;

    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic [DATA_W-1:0]  rdata_ext;

    logic               accept, capture, fault_d, valid_d, busy;

    // Decode the presented instruction: legality, store byte enables and lane replication.
    always_comb begin
        req_any   = dmem_read_en | dmem_write_en;
        req_write = dmem_write_en;
        legal     = 1'b0;
        be_c      = 4'b0000;
        wdata_c   = '0;
        if (req_write) begin
            case (func3)
                3'b000: begin
                    legal   = 1'b1;
                    be_c    = 4'b0001 << addr[1:0];
                    wdata_c = {4{store_data[7:0]}};
                end
                3'b001: begin
                    legal   = ~addr[0];
                    be_c    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{store_data[15:0]}};
                end
                3'b010: begin
                    legal   = (addr[1:0] == 2'b00);
                    be_c    = 4'b1111;
                    wdata_c = store_data;
                end
                default: legal = 1'b0;
            endcase
        end else begin
            case (func3)
                3'b000, 3'b100: legal = 1'b1;
                3'b001, 3'b101: legal = ~addr[0];
                3'b010:         legal = (addr[1:0] == 2'b00);
                default:        legal = 1'b0;
            endcase
        end
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        case (off_q)
            2'd0:    lane_byte = bus.mem_rdata[7:0];
            2'd1:    lane_byte = bus.mem_rdata[15:8];
            2'd2:    lane_byte = bus.mem_rdata[23:16];
            default: lane_byte = bus.mem_rdata[31:24];
        endcase
        lane_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (func3_q)
            3'b000:  rdata_ext = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
            3'b100:  rdata_ext = {{(DATA_W-8){1'b0}}, lane_byte};
            3'b001:  rdata_ext = {{(DATA_W-16){lane_half[15]}}, lane_half};
            3'b101:  rdata_ext = {{(DATA_W-16){1'b0}}, lane_half};
            default: rdata_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        accept  = 1'b0;
        capture = 1'b0;
        fault_d = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    if (legal) begin
                        accept  = 1'b1;
                        busy    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                busy = 1'b1;
                if (bus.mem_ack) begin
                    capture = ~we_q;
                    valid_d = ~we_q;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    fault_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stall is combinational so the core holds in the accept cycle; reset forces it low.
    assign stall = busy & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            off_q      <= 2'b00;
            func3_q    <= 3'b000;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            load_data  <= '0;
            load_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                off_q   <= addr[1:0];
                func3_q <= func3;
                we_q    <= req_write;
                wdata_q <= req_write ? wdata_c : '0;
                be_q    <= req_write ? be_c : 4'b0000;
            end
            if (capture) begin
                load_data <= rdata_ext;
            end
            load_valid <= valid_d;
            fault      <= fault_d;
        end
    end

    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, timeout and reset sequences,
// then random accesses checked against a byte-level reference model.
module tb_load_store_unit;

    localparam int unsigned TIMEOUT = 255;

    logic        clk;
    logic        rst_n;
    logic        dmem_read_en;
    logic        dmem_write_en;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;

    load_store_unit_if bus ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_read_en (dmem_read_en),
        .dmem_write_en(dmem_write_en),
        .func3        (func3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .fault        (fault),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          dly;      // REQ cycles before ack; negative = never ack
        logic        x_fault;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic [31:0] x_ldata;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_ld_last = 32'h0;
    vec_t        tbl[15];

    function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endfunction

    function automatic vec_t mk(logic re, logic we, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] sd, logic [31:0] rd, int dly, logic xf,
                                logic [3:0] xbe, logic [31:0] xwd, logic [31:0] xld);
        vec_t v;
        v.re = re; v.we = we; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd; v.dly = dly;
        v.x_fault = xf; v.x_be = xbe; v.x_wdata = xwd; v.x_ldata = xld;
        return v;
    endfunction

    // Reference: access size in bytes, natural alignment, byte-wise lane placement.
    function automatic vec_t ref_model(vec_t v);
        vec_t        r;
        int          nb;
        int          off;
        logic        ok;
        logic [31:0] val;
        logic [31:0] mask;
        r   = v;
        nb  = 1 << v.f3[1:0];
        off = int'(v.a[1:0]);
        if (v.we) ok = (v.f3 < 3'd3);
        else      ok = (v.f3[1:0] != 2'b11) && (v.f3 != 3'b110);
        ok = ok && ((off % nb) == 0);
        r.x_fault = ~ok;
        r.x_be    = 4'b0000;
        r.x_wdata = 32'h0;
        r.x_ldata = 32'h0;
        if (ok && v.we) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + nb) r.x_be[i] = 1'b1;
                r.x_wdata[8*i +: 8] = v.sd[8*(i % nb) +: 8];
            end
        end else if (ok) begin
            val = v.rd >> (8 * off);
            if (nb < 4) begin
                mask = (32'h1 << (8 * nb)) - 32'h1;
                val  = val & mask;
                if (!v.f3[2] && val[8*nb-1]) val = val | ~mask;
            end
            r.x_ldata = val;
        end
        return r;
    endfunction

    task automatic run_access(input vec_t v, input string n);
        int          reqc;
        int          guard;
        logic        stall0, stall_ok, stable, f_seen, lv_seen, st_done, post;
        logic [31:0] m_addr, m_wdata, ld_seen;
        logic [3:0]  m_be;
        logic        m_we;
        @(negedge clk);
        dmem_read_en  = v.re;
        dmem_write_en = v.we;
        func3         = v.f3;
        addr          = v.a;
        store_data    = v.sd;
        bus.mem_ack   = 1'b0;
        #1 stall0 = stall;
        reqc = 0; guard = 0; stall_ok = 1'b1; stable = 1'b1;
        m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0; m_we = 1'b0;
        @(negedge clk);
        while (bus.mem_req && guard < 400) begin
            if (reqc == 0) begin
                m_addr = bus.mem_addr; m_wdata = bus.mem_wdata;
                m_be = bus.mem_be; m_we = bus.mem_we;
            end else if (bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata ||
                         bus.mem_be !== m_be || bus.mem_we !== m_we) begin
                stable = 1'b0;
            end
            reqc++;
            if (!stall) stall_ok = 1'b0;
            if (v.dly >= 0 && reqc == v.dly + 1) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = v.rd;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
            end
            @(negedge clk);
            guard++;
        end
        bus.mem_ack = 1'b0;
        f_seen = fault; lv_seen = load_valid; ld_seen = load_data; st_done = stall;
        dmem_read_en  = 1'b0;
        dmem_write_en = 1'b0;
        @(negedge clk);
        post = fault | load_valid | bus.mem_req | stall;

        if (v.re && !v.we && !v.x_fault && v.dly >= 0) exp_ld_last = v.x_ldata;

        chk({n, ".fault"}, 32'(f_seen), 32'(v.x_fault));
        if (v.dly < 0) begin
            chk({n, ".stall0"}, 32'(stall0), 32'd1);
            chk({n, ".timeout_len"},
                32'((reqc == int'(TIMEOUT)) || (reqc == int'(TIMEOUT) + 1)), 32'd1);
            chk({n, ".lv"}, 32'(lv_seen), 32'd0);
        end else if (v.x_fault) begin
            chk({n, ".reqc"}, 32'(reqc), 32'd0);
            chk({n, ".stall0"}, 32'(stall0), 32'd0);
            chk({n, ".lv"}, 32'(lv_seen), 32'd0);
        end else begin
            chk({n, ".stall0"}, 32'(stall0), 32'd1);
            chk({n, ".reqc"}, 32'(reqc), 32'(v.dly + 1));
            chk({n, ".stall_req"}, 32'(stall_ok), 32'd1);
            chk({n, ".stable"}, 32'(stable), 32'd1);
            chk({n, ".addr"}, m_addr, {v.a[31:2], 2'b00});
            chk({n, ".we"}, 32'(m_we), 32'(v.we));
            chk({n, ".be"}, 32'(m_be), 32'(v.x_be));
            if (v.we) chk({n, ".wdata"}, m_wdata, v.x_wdata);
            chk({n, ".stall_done"}, 32'(st_done), 32'd0);
            chk({n, ".lv"}, 32'(lv_seen), 32'(!v.we));
        end
        chk({n, ".ldata"}, ld_seen, exp_ld_last);
        chk({n, ".quiet"}, 32'(post), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   sel;
        rst_n = 1'b0;
        dmem_read_en = 1'b0; dmem_write_en = 1'b0;
        func3 = 3'b000; addr = 32'h0; store_data = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

        //        re  we  f3      addr          store_data    rdata        dly flt be       wdata         ldata
        tbl[0]  = mk(1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'b0000, 32'h0,        32'hDEADBEEF);
        tbl[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 4'b0000, 32'h0,        32'hFFFFFF80);
        tbl[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 1, 0, 4'b0000, 32'h0,        32'h00000080);
        tbl[3]  = mk(0, 1, 3'b001, 32'h22,  32'h1234ABCD, 32'h0,        0, 0, 4'b1100, 32'hABCDABCD, 32'h0);
        tbl[4]  = mk(1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        tbl[5]  = mk(1, 0, 3'b110, 32'h100, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        tbl[6]  = mk(0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0);
        tbl[7]  = mk(0, 1, 3'b010, 32'h40,  32'hCAFEF00D, 32'h0,        2, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
        tbl[8]  = mk(1, 0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 0, 0, 4'b0000, 32'h0,        32'hFFFF8001);
        tbl[9]  = mk(1, 0, 3'b101, 32'h100, 32'h0,        32'h8001F00F, 3, 0, 4'b0000, 32'h0,        32'h0000F00F);
        tbl[10] = mk(0, 1, 3'b001, 32'h21,  32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        tbl[11] = mk(0, 1, 3'b011, 32'h20,  32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        tbl[12] = mk(1, 1, 3'b010, 32'h30,  32'h11223344, 32'h55555555, 0, 0, 4'b1111, 32'h11223344, 32'h0);
        tbl[13] = mk(1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 0, 4'b0000, 32'h0,        32'h0000007F);
        tbl[14] = mk(0, 1, 3'b010, 32'h80,  32'h0BADF00D, 32'h0,       -1, 1, 4'b1111, 32'h0BADF00D, 32'h0);

        repeat (3) @(negedge clk);
        chk("rst.mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.load_valid", 32'(load_valid), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.load_data", load_data, 32'h0);
        chk("rst.mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst.mem_addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_access(tbl[i], $sformatf("tbl%0d", i));

        // Reset asserted mid-transaction drops the request without waiting for ack.
        @(negedge clk);
        dmem_read_en = 1'b1; func3 = 3'b010; addr = 32'h200;
        repeat (3) @(negedge clk);
        chk("arst.req_before", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.mem_req", 32'(bus.mem_req), 32'd0);
        chk("arst.stall", 32'(stall), 32'd0);
        @(negedge clk);
        dmem_read_en = 1'b0;
        rst_n = 1'b1;
        exp_ld_last = 32'h0;
        run_access(mk(1, 0, 3'b010, 32'h204, 32'h0, 32'h01234567, 0, 0, 4'b0000, 32'h0, 32'h01234567),
                   "arst.lw");

        for (int i = 0; i < 150; i++) begin
            sel    = int'($urandom_range(1, 3));
            v.re   = sel[0];
            v.we   = sel[1];
            v.f3   = 3'($urandom_range(0, 7));
            v.a    = $urandom;
            v.sd   = $urandom;
            v.rd   = $urandom;
            v.dly  = int'($urandom_range(0, 3));
            v      = ref_model(v);
            run_access(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
